wavetable_sample_feeder: RTL and testbench

Upstream sample source for the music playback state machine. It steps a phase accumulator through a waveform ROM table and buffers 16-bit samples in a small FIFO. It presents the FIFO head as LDATA/RDATA, and pops one sample each time the playback stage signals that the audio interface has consumed a word (data_over). One START plays exactly NOTE_LEN samples at a pitch set by PHASE_INC.

---
 rtl/wavetable_sample_feeder_pkg.sv | 20 ++
 rtl/wavetable_sample_feeder_if.sv | 45 ++++
 rtl/wavetable_sample_feeder_fifo.sv | 63 ++++++
 rtl/wavetable_sample_feeder.sv | 155 +++++++++++++++
 tb/tb_wavetable_sample_feeder.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wavetable_sample_feeder_pkg.sv
// Shared types and default widths for the wavetable feeder and playback stage.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package music_pkg;

  localparam int ADDR_W_DEF     = 8;
  localparam int DATA_W_DEF     = 16;
  localparam int PHASE_W_DEF    = 24;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int NOTE_LEN_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_WAIT_ROM = 3'd2,
    ST_HOLD     = 3'd3,
    ST_DRAIN    = 3'd4
  } feeder_state_e;

endpackage

// File: rtl/wavetable_sample_feeder_if.sv
// Bundle of control, ROM and sample-output signals of the wavetable feeder.
// Latency: none (wiring only).
// Backpressure: none; the feeder (slave) is driven by the playback/ROM side (master).
// Build option VOLUME_SCALE_EN adds the 4-bit VOLUME input.
interface wavetable_sample_feeder_if
  import music_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int PHASE_W = PHASE_W_DEF
);
  logic                  START;
  logic                  STOP;
  logic [PHASE_W-1:0]    PHASE_INC;
  logic [NOTE_LEN_W-1:0] NOTE_LEN;
  logic                  SAMPLE_REQ;
  logic [ADDR_W-1:0]     ROM_ADDR;
  logic [DATA_W-1:0]     ROM_DATA;
  logic [DATA_W-1:0]     LDATA;
  logic [DATA_W-1:0]     RDATA;
  logic                  SAMPLE_VALID;
  logic                  BUSY;
  logic                  NOTE_DONE;
  logic                  UNDERRUN;
`ifdef VOLUME_SCALE_EN
  logic [3:0]            VOLUME;
`endif

  modport master (
`ifdef VOLUME_SCALE_EN
    output VOLUME,
`endif
    output START, STOP, PHASE_INC, NOTE_LEN, SAMPLE_REQ, ROM_DATA,
    input  ROM_ADDR, LDATA, RDATA, SAMPLE_VALID, BUSY, NOTE_DONE, UNDERRUN
  );

  modport slave (
`ifdef VOLUME_SCALE_EN
    input  VOLUME,
`endif
    input  START, STOP, PHASE_INC, NOTE_LEN, SAMPLE_REQ, ROM_DATA,
    output ROM_ADDR, LDATA, RDATA, SAMPLE_VALID, BUSY, NOTE_DONE, UNDERRUN
  );

endinterface

// File: rtl/wavetable_sample_feeder_fifo.sv
// sample_fifo: synchronous FIFO with flush, occupancy count and head peek.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: pushes are dropped when full (unless popping that cycle); pops on empty are ignored.
// Ports: clk_i/rst_i (async active-high), push_i/push_data_i, pop_i, flush_i,
//        count_o, full_o, empty_o, head_o (0 while empty).
module sample_fifo #(
  parameter  int FIFO_DEPTH = 4,
  parameter  int DATA_W     = 16,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [DATA_W-1:0] head_o
);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once counted as valid.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/wavetable_sample_feeder.sv
// Wavetable sample feeder: steps a phase accumulator through a waveform ROM and
// buffers samples for playback; one START plays NOTE_LEN samples.
// Latency: START cycle 0 -> ROM address cycle 1 -> SAMPLE_VALID in cycle 3; fill rate 1 sample / 2 cycles.
// Backpressure: fetching pauses (HOLD) while the buffer is full; SAMPLE_REQ pops the head.
// Ports: CLK, RESET (async active-high), bus (slave modport): START/STOP/PHASE_INC/NOTE_LEN/
//        SAMPLE_REQ in, ROM_ADDR/ROM_DATA ROM link, LDATA/RDATA/SAMPLE_VALID/BUSY/NOTE_DONE/UNDERRUN out.
// Build option VOLUME_SCALE_EN: LDATA/RDATA = (head * VOLUME) >>> 4.
module wavetable_sample_feeder
  import music_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int PHASE_W    = PHASE_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                      CLK,
  input  logic                      RESET,
  wavetable_sample_feeder_if.slave  bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  feeder_state_e         state_q;
  logic [PHASE_W-1:0]    phase_q;
  logic [PHASE_W-1:0]    inc_q;
  logic [NOTE_LEN_W-1:0] remaining_q;
  logic [ADDR_W-1:0]     rom_addr_q;
  logic                  note_done_q;
  logic                  underrun_q;

  logic              fifo_push, fifo_pop, fifo_flush;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W-1:0] fifo_head;
  logic              pop_ok;
  logic              stop_act;
  logic [CNT_W-1:0]  cnt_after_push;
  logic              will_full;
  logic [DATA_W-1:0] sample_out;

  assign pop_ok     = bus.SAMPLE_REQ & ~fifo_empty;
  assign stop_act   = bus.STOP & (state_q != ST_IDLE);
  assign fifo_flush = stop_act;
  // A STOP during WAIT_ROM discards the word arriving from the ROM.
  assign fifo_push  = (state_q == ST_WAIT_ROM) & ~stop_act;
  assign fifo_pop   = bus.SAMPLE_REQ;

  // Occupancy after this cycle's push (and possible pop); only used in WAIT_ROM.
  assign cnt_after_push = fifo_count + CNT_W'(1) - CNT_W'(pop_ok);
  assign will_full      = (cnt_after_push == CNT_W'(FIFO_DEPTH));

  sample_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (DATA_W)
  ) u_fifo (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .push_i      (fifo_push),
    .push_data_i (bus.ROM_DATA),
    .pop_i       (fifo_pop),
    .flush_i     (fifo_flush),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      inc_q       <= '0;
      remaining_q <= '0;
      rom_addr_q  <= '0;
      note_done_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      note_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.START && !bus.STOP) begin
            if (bus.NOTE_LEN != '0) begin
              inc_q       <= bus.PHASE_INC;
              phase_q     <= '0;
              remaining_q <= bus.NOTE_LEN;
              rom_addr_q  <= '0;
              underrun_q  <= 1'b0;
              state_q     <= ST_FETCH;
            end else begin
              note_done_q <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          phase_q     <= phase_q + inc_q;
          remaining_q <= remaining_q - NOTE_LEN_W'(1);
          state_q     <= ST_WAIT_ROM;
        end
        ST_WAIT_ROM: begin
          // ROM address is loaded on entry to FETCH so it is a clean register output.
          if (remaining_q == '0) begin
            state_q <= ST_DRAIN;
          end else if (will_full) begin
            state_q <= ST_HOLD;
          end else begin
            rom_addr_q <= phase_q[PHASE_W-1 -: ADDR_W];
            state_q    <= ST_FETCH;
          end
        end
        ST_HOLD: begin
          if (!fifo_full) begin
            rom_addr_q <= phase_q[PHASE_W-1 -: ADDR_W];
            state_q    <= ST_FETCH;
          end
        end
        ST_DRAIN: begin
          if (fifo_empty) begin
            state_q <= ST_IDLE;
          end else if (pop_ok && fifo_count == CNT_W'(1)) begin
            note_done_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Sets after the START clear, so a request in the START cycle still counts.
      if (bus.SAMPLE_REQ && fifo_empty) underrun_q <= 1'b1;

      // Abort overrides every transition above and suppresses completion.
      if (stop_act) begin
        state_q     <= ST_IDLE;
        note_done_q <= 1'b0;
      end
    end
  end

`ifdef VOLUME_SCALE_EN
  logic signed [DATA_W+4:0] scaled_prod;
  // Volume is an unsigned 0..15 gain in sixteenths; the zero-extend keeps the multiply signed.
  assign scaled_prod = $signed(fifo_head) * $signed({1'b0, bus.VOLUME});
  assign sample_out  = scaled_prod[DATA_W+3:4];
`else
  assign sample_out  = fifo_head;
`endif

  assign bus.ROM_ADDR     = rom_addr_q;
  assign bus.LDATA        = sample_out;
  assign bus.RDATA        = sample_out;
  assign bus.SAMPLE_VALID = ~fifo_empty;
  assign bus.BUSY         = (state_q != ST_IDLE);
  assign bus.NOTE_DONE    = note_done_q;
  assign bus.UNDERRUN     = underrun_q;

endmodule

// File: tb/tb_wavetable_sample_feeder.sv
// Self-checking bench for wavetable_sample_feeder: directed scenarios plus random notes
// scored against a phase-arithmetic reference of the expected sample stream.
// Synchronous 1-cycle ROM model; inputs driven and outputs sampled 1 time unit after posedge.
module tb_wavetable_sample_feeder;
  import music_pkg::*;

  localparam logic [3:0] VOL = 4'hB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wavetable_sample_feeder_if bus ();

  wavetable_sample_feeder dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  logic [15:0] rom [256];
  always @(posedge clk) bus.ROM_DATA <= rom[bus.ROM_ADDR];

  int checks = 0;
  int errors = 0;
  int nd_cnt = 0;
  always @(negedge clk) if (!rst && bus.NOTE_DONE) nd_cnt++;

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_note(logic [23:0] inc, logic [15:0] len);
    bus.PHASE_INC = inc;
    bus.NOTE_LEN  = len;
    bus.START     = 1'b1;
    tick();
    bus.START     = 1'b0;
  endtask

  // Sample k of a note reads the table at the top 8 bits of k*inc modulo 2^24.
  function automatic logic [7:0] addr_of(logic [23:0] inc, int k);
    logic [31:0] p;
    p = 32'(k) * 32'(inc);
    return p[23:16];
  endfunction

  function automatic logic [15:0] scale(logic [15:0] x);
`ifdef VOLUME_SCALE_EN
    logic signed [20:0] p;
    p = $signed(x) * $signed({1'b0, VOL});
    return p[19:4];
`else
    return x;
`endif
  endfunction

  initial begin
    logic [15:0] got [$];
    logic [15:0] expq [$];
    logic [23:0] inc;
    int len, nd0, cyc;
    logic exp_under;

    bus.START = 0; bus.STOP = 0; bus.PHASE_INC = '0; bus.NOTE_LEN = '0; bus.SAMPLE_REQ = 0;
`ifdef VOLUME_SCALE_EN
    bus.VOLUME = VOL;
`endif
    for (int i = 0; i < 256; i++) rom[i] = 16'(i);

    // Reset values
    #2;
    chk("rst_rom_addr", 32'(bus.ROM_ADDR), 0);
    chk("rst_ldata", 32'(bus.LDATA), 0);
    chk("rst_rdata", 32'(bus.RDATA), 0);
    chk("rst_valid", 32'(bus.SAMPLE_VALID), 0);
    chk("rst_busy", 32'(bus.BUSY), 0);
    chk("rst_note_done", 32'(bus.NOTE_DONE), 0);
    chk("rst_underrun", 32'(bus.UNDERRUN), 0);
    tick(2);
    rst = 1'b0;
    tick();

    // Basic note: address sequence, 3-cycle latency, fill to full with no requests
    start_note(24'h010000, 16'd4);
    chk("lat_c1_valid", 32'(bus.SAMPLE_VALID), 0);
    chk("seq_addr0", 32'(bus.ROM_ADDR), 0);
    tick();
    chk("lat_c2_valid", 32'(bus.SAMPLE_VALID), 0);
    tick();
    chk("lat_c3_valid", 32'(bus.SAMPLE_VALID), 1);
    chk("seq_addr1", 32'(bus.ROM_ADDR), 1);
    tick(2);
    chk("seq_addr2", 32'(bus.ROM_ADDR), 2);
    tick(2);
    chk("seq_addr3", 32'(bus.ROM_ADDR), 3);
    tick(10);
    chk("fill_busy", 32'(bus.BUSY), 1);
    chk("fill_valid", 32'(bus.SAMPLE_VALID), 1);
    chk("fill_ldata", 32'(bus.LDATA), 32'(scale(16'h0000)));
    chk("fill_rdata", 32'(bus.RDATA), 32'(scale(16'h0000)));

    // Drain with spaced pops
    nd0 = nd_cnt;
    for (int k = 0; k < 4; k++) begin
      chk("pop_ldata", 32'(bus.LDATA), 32'(scale(16'(k))));
      bus.SAMPLE_REQ = 1'b1;
      tick();
      bus.SAMPLE_REQ = 1'b0;
      if (k < 3) begin
        chk("pop_no_done", 32'(bus.NOTE_DONE), 0);
        tick(9);
      end
    end
    chk("done_pulse", 32'(bus.NOTE_DONE), 1);
    tick();
    chk("done_clear", 32'(bus.NOTE_DONE), 0);
    chk("done_busy", 32'(bus.BUSY), 0);
    chk("done_empty_ldata", 32'(bus.LDATA), 0);
    tick(3);
    chk("done_once", 32'(nd_cnt - nd0), 1);

    // Reset during WAIT_ROM with 3 samples buffered
    start_note(24'h010000, 16'd8);
    tick(7);
    chk("mid_valid", 32'(bus.SAMPLE_VALID), 1);
    chk("mid_busy", 32'(bus.BUSY), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus.SAMPLE_VALID), 0);
    chk("mid_rst_busy", 32'(bus.BUSY), 0);
    chk("mid_rst_ldata", 32'(bus.LDATA), 0);
    chk("mid_rst_addr", 32'(bus.ROM_ADDR), 0);
    tick(2);
    rst = 1'b0;
    tick(2);
    chk("mid_after_valid", 32'(bus.SAMPLE_VALID), 0);
    chk("mid_after_busy", 32'(bus.BUSY), 0);

    // Phase wrap-around
    start_note(24'hFF0000, 16'd3);
    chk("wrap_addr0", 32'(bus.ROM_ADDR), 32'h00);
    tick(2);
    chk("wrap_addr1", 32'(bus.ROM_ADDR), 32'hFF);
    tick(2);
    chk("wrap_addr2", 32'(bus.ROM_ADDR), 32'hFE);
    tick(6);
    for (int k = 0; k < 3; k++) begin
      bus.SAMPLE_REQ = 1'b1;
      chk("wrap_data", 32'(bus.LDATA), 32'(scale(rom[addr_of(24'hFF0000, k)])));
      tick();
    end
    bus.SAMPLE_REQ = 1'b0;
    chk("wrap_done", 32'(bus.NOTE_DONE), 1);
    tick(3);

    // Requests every cycle from START: underrun, yet full in-order delivery
    got.delete();
    bus.SAMPLE_REQ = 1'b1;
    start_note(24'h010000, 16'd10);
    tick();
    chk("under_set", 32'(bus.UNDERRUN), 1);
    cyc = 0;
    while (cyc < 200) begin
      if (bus.SAMPLE_VALID) got.push_back(bus.LDATA);
      if (!bus.BUSY) break;
      tick();
      cyc++;
    end
    bus.SAMPLE_REQ = 1'b0;
    chk("under_timeout", 32'(cyc < 200), 1);
    chk("under_count", 32'(got.size()), 10);
    for (int k = 0; k < got.size() && k < 10; k++)
      chk("under_order", 32'(got[k]), 32'(scale(16'(k))));
    tick(2);
    chk("under_sticky", 32'(bus.UNDERRUN), 1);

    // STOP in HOLD with a full buffer
    start_note(24'h010000, 16'd10);
    chk("start_clears_under", 32'(bus.UNDERRUN), 0);
    tick(12);
    chk("hold_valid", 32'(bus.SAMPLE_VALID), 1);
    chk("hold_busy", 32'(bus.BUSY), 1);
    nd0 = nd_cnt;
    bus.STOP = 1'b1;
    tick();
    bus.STOP = 1'b0;
    chk("stop_valid", 32'(bus.SAMPLE_VALID), 0);
    chk("stop_busy", 32'(bus.BUSY), 0);
    chk("stop_no_done", 32'(bus.NOTE_DONE), 0);
    tick(3);
    chk("stop_no_done_cnt", 32'(nd_cnt - nd0), 0);

    // Zero-length note
    nd0 = nd_cnt;
    start_note(24'h123456, 16'd0);
    chk("zero_done", 32'(bus.NOTE_DONE), 1);
    chk("zero_busy", 32'(bus.BUSY), 0);
    tick();
    chk("zero_done_clear", 32'(bus.NOTE_DONE), 0);
    tick(3);
    chk("zero_no_sample", 32'(bus.SAMPLE_VALID), 0);
    chk("zero_done_once", 32'(nd_cnt - nd0), 1);

    // Random notes on a random table with random consumer timing
    for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
    for (int n = 0; n < 6; n++) begin
      inc = 24'($urandom);
      len = $urandom_range(1, 12);
      expq.delete();
      for (int k = 0; k < len; k++) expq.push_back(scale(rom[addr_of(inc, k)]));
      exp_under = 1'b0;
      nd0 = nd_cnt;
      start_note(inc, 16'(len));
      cyc = 0;
      while (cyc < 600) begin
        if (!bus.BUSY) break;
        bus.SAMPLE_REQ = ($urandom_range(0, 2) == 0);
        if (bus.SAMPLE_REQ && bus.SAMPLE_VALID) begin
          if (expq.size() > 0) begin
            chk("rand_ldata", 32'(bus.LDATA), 32'(expq[0]));
            chk("rand_rdata", 32'(bus.RDATA), 32'(expq[0]));
            void'(expq.pop_front());
          end else begin
            chk("rand_extra_sample", 32'(bus.SAMPLE_VALID), 0);
          end
        end else if (bus.SAMPLE_REQ) begin
          exp_under = 1'b1;
          chk("rand_empty_ldata", 32'(bus.LDATA), 0);
        end
        tick();
        cyc++;
      end
      bus.SAMPLE_REQ = 1'b0;
      tick(2);
      chk("rand_timeout", 32'(bus.BUSY), 0);
      chk("rand_left", 32'(expq.size()), 0);
      chk("rand_underrun", 32'(bus.UNDERRUN), 32'(exp_under));
      chk("rand_done_once", 32'(nd_cnt - nd0), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
